// File: rtl/display_uart_tx.sv
// display_uart_tx: streams the display buffer as 8N1 UART frames (CR then every character)
// whenever the buffer contents change or a refresh is requested.
module display_uart_tx #(
    parameter int DisplayBufferSize = 256,
    parameter int ClksPerBit        = 868,
    parameter int CharIndexWidth    = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DisplayBufferSize-1:0] DisplayBuffer,
    input  logic                         TxEn,
    input  logic                         Refresh,
    output logic                         Tx,
    output logic                         Busy,
    output logic                         FrameDone
);
    localparam int NCHAR = DisplayBufferSize / 8;
    localparam int BW    = $clog2(ClksPerBit);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                       state_q;
    logic [DisplayBufferSize-1:0] shadow_q;
    logic                         pending_q;
    logic [BW-1:0]                baud_q;
    logic [2:0]                   bit_q;
    logic [CharIndexWidth-1:0]    char_q;
    logic [7:0]                   shift_q;
    logic                         tx_q;
    logic                         busy_q;
    logic                         done_q;

    logic       trigger;
    logic       bit_end;
    logic       more;
    logic [7:0] raw_char;
    logic [7:0] next_char;

    assign trigger   = state_q == IDLE && TxEn && (DisplayBuffer != shadow_q || Refresh || pending_q);
    assign bit_end   = baud_q == BW'(ClksPerBit - 1);
    assign more      = char_q < CharIndexWidth'(NCHAR);
    // address 0 is the top byte of the buffer
    assign raw_char  = 8'(shadow_q >> (8 * (NCHAR - 1 - int'(char_q))));
    assign next_char = raw_char == 8'h00 ? 8'h20 : raw_char;

    assign Tx        = tx_q;
    assign Busy      = busy_q;
    assign FrameDone = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            baud_q    <= '0;
            bit_q     <= '0;
            char_q    <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            baud_q    <= (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
            pending_q <= trigger ? 1'b0 : (pending_q | Refresh);
            case (state_q)
                IDLE: if (trigger) begin
                    shadow_q <= DisplayBuffer;
                    shift_q  <= 8'h0D;
                    char_q   <= '0;
                    tx_q     <= 1'b0;
                    busy_q   <= 1'b1;
                    state_q  <= START;
                end
                START: if (bit_end) begin
                    tx_q    <= shift_q[0];
                    shift_q <= shift_q >> 1;
                    bit_q   <= '0;
                    state_q <= DATA;
                end
                DATA: if (bit_end) begin
                    tx_q    <= bit_q == 3'd7 ? 1'b1 : shift_q[0];
                    shift_q <= shift_q >> 1;
                    bit_q   <= bit_q + 3'd1;
                    state_q <= bit_q == 3'd7 ? STOP : DATA;
                end
                STOP: if (bit_end) begin
                    if (more) begin
                        shift_q <= next_char;
                        char_q  <= char_q + 1'b1;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_display_uart_tx.sv
// tb_display_uart_tx: directed bench for display_uart_tx with 4 characters and 4 clocks per bit;
// every output cycle is logged and frames are compared against hand-written byte lists.
module tb_display_uart_tx;
    localparam int LOG = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        TxEn = 1'b1;
    logic        Refresh = 1'b0;
    logic [31:0] DisplayBuffer = '0;
    logic        Tx;
    logic        Busy;
    logic        FrameDone;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit tx_log [LOG];
    bit busy_log [LOG];
    bit done_log [LOG];

    display_uart_tx #(
        .DisplayBufferSize(32),
        .ClksPerBit(4),
        .CharIndexWidth(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .DisplayBuffer(DisplayBuffer),
        .TxEn(TxEn),
        .Refresh(Refresh),
        .Tx(Tx),
        .Busy(Busy),
        .FrameDone(FrameDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // log[n] holds the outputs registered at the n-th rising edge
    always @(negedge clk) begin
        if (cyc < LOG) begin
            tx_log[cyc]   <= Tx;
            busy_log[cyc] <= Busy;
            done_log[cyc] <= FrameDone;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_refresh();
        Refresh = 1'b1;
        tick(1);
        Refresh = 1'b0;
    endtask

    function automatic bit tx_at(input int c);
        return (c >= 0 && c < LOG) ? tx_log[c] : 1'b1;
    endfunction

    function automatic bit busy_at(input int c);
        return (c >= 0 && c < LOG) ? busy_log[c] : 1'b0;
    endfunction

    function automatic bit done_at(input int c);
        return (c >= 0 && c < LOG) ? done_log[c] : 1'b0;
    endfunction

    function automatic int find_fall(input int from, input int to);
        for (int c = from; c <= to; c++)
            if (!tx_at(c)) return c;
        return -1;
    endfunction

    function automatic int count_done(input int from, input int to);
        int n = 0;
        for (int c = from; c <= to; c++) n += int'(done_at(c));
        return n;
    endfunction

    function automatic int count_busy(input int from, input int to);
        int n = 0;
        for (int c = from; c <= to; c++) n += int'(busy_at(c));
        return n;
    endfunction

    // exp holds the five characters of a frame, first character in the top byte
    task automatic check_frame(input string tag, input int s, input logic [39:0] exp);
        int  mism = 0;
        bit  e;
        logic [7:0] b;
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < 8; i++) b[i] = tx_at(s + 40 * j + 4 + 4 * i + 2);
            check($sformatf("%s_byte%0d", tag, j), int'(b), int'(exp[39 - 8 * j -: 8]));
        end
        for (int k = 0; k < 200; k++) begin
            e = (k % 40) < 4 ? 1'b0 : (k % 40) < 36 ? exp[32 - 8 * (k / 40) + ((k % 40) - 4) / 4] : 1'b1;
            mism += int'(tx_at(s + k) != e);
        end
        check($sformatf("%s_wave", tag), mism, 0);
        check($sformatf("%s_done", tag), int'(done_at(s + 200)), 1);
        check($sformatf("%s_early_done", tag), count_done(s, s + 199), 0);
        check($sformatf("%s_busy_first", tag), int'(busy_at(s)), 1);
        check($sformatf("%s_busy_last", tag), int'(busy_at(s + 199)), 1);
        check($sformatf("%s_busy_after", tag), int'(busy_at(s + 200)), 0);
    endtask

    initial begin
        int c;
        int s;
        logic [9:0] pat;

        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(50);
        check("rst_no_frame", find_fall(1, cyc - 1), -1);
        check("rst_busy", count_busy(1, cyc - 1), 0);
        check("rst_done", count_done(1, cyc - 1), 0);

        c = cyc;
        DisplayBuffer = 32'h41420043;
        wait_until(c + 215);
        s = find_fall(c, c + 10);
        check("s1_start", s, c + 1);
        check_frame("s1", s, 40'h0D41422043);
        pat = '0;
        for (int i = 0; i < 10; i++) pat = {pat[8:0], tx_at(s + 40 + 4 * i + 2)};
        check("s6_pattern41", int'(pat), 10'h105);
        check("s6_stop_end", int'(tx_at(s + 39)), 1);
        check("s6_no_gap", int'(tx_at(s + 40)), 0);

        c = cyc;
        DisplayBuffer = 32'h41424344;
        wait_until(c + 215);
        check("s2_change_start", find_fall(c, c + 10), c + 1);

        c = cyc;
        pulse_refresh();
        s = c + 1;
        wait_until(s + 20);
        pulse_refresh();
        wait_until(s + 60);
        pulse_refresh();
        wait_until(s + 440);
        check("s2_start", find_fall(c, c + 10), s);
        check_frame("s2a", s, 40'h0D41424344);
        check("s2b_start", find_fall(s + 200, s + 300), s + 201);
        check_frame("s2b", s + 201, 40'h0D41424344);
        check("s2_idle", find_fall(s + 402, s + 438), -1);

        c = cyc;
        pulse_refresh();
        s = c + 1;
        wait_until(s + 49);
        DisplayBuffer = 32'h31323334;
        wait_until(s + 440);
        check("s3_start", find_fall(c, c + 10), s);
        check_frame("s3a", s, 40'h0D41424344);
        check("s3b_start", find_fall(s + 200, s + 300), s + 201);
        check_frame("s3b", s + 201, 40'h0D31323334);
        check("s3_idle", find_fall(s + 402, s + 438), -1);

        c = cyc;
        TxEn = 1'b0;
        DisplayBuffer = 32'h55555555;
        wait_until(c + 50);
        check("s4_hold", find_fall(c, c + 48), -1);
        c = cyc;
        TxEn = 1'b1;
        s = c + 1;
        wait_until(s + 59);
        TxEn = 1'b0;
        wait_until(s + 230);
        check("s4_start", find_fall(c, c + 10), s);
        check_frame("s4", s, 40'h0D55555555);
        check("s4_idle", find_fall(s + 201, s + 228), -1);

        TxEn = 1'b1;
        c = cyc;
        pulse_refresh();
        s = c + 1;
        wait_until(s + 29);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        wait_until(s + 33 + 215);
        check("s5_start", find_fall(c, c + 10), s);
        check("s5_line_low", int'(tx_at(s + 29)), 0);
        check("s5_rst_tx", int'(tx_at(s + 30)), 1);
        check("s5_rst_busy", int'(busy_at(s + 30)), 0);
        check("s5_rst_done", count_done(s, s + 32), 0);
        check("s5_restart", find_fall(s + 30, s + 60), s + 33);
        check_frame("s5b", s + 33, 40'h0D55555555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
